// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads over req/ack, one-entry skid
// buffer for stall, drop flag for redirect. Optional macro: IFETCH_PERF_EN.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   imem_req, imem_addr    read request / word address to instruction memory
//   imem_ack, imem_rdata   one-cycle ack with read data
//   stall                  downstream cannot accept the presented instruction
//   branch_taken/_target   redirect pulse and target from execute
//   instruction_memory     instruction presented to the decoder
//   instr_valid, pc_out    valid flag and PC of the presented instruction
//   bubble_count           (IFETCH_PERF_EN only) saturating bubble counter
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction_memory,
  output logic        instr_valid,
  output logic [31:0] pc_out
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pco_q, pco_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic        drop_q, drop_d;

  logic        fire;
  logic        slot_free;
  logic [31:0] tgt;
  logic        unused_tgt;

  assign fire      = (state_q == FETCH) && imem_ack;
  assign slot_free = !valid_q || !stall;
  assign tgt       = {branch_target[31:2], 2'b00};
  assign unused_tgt = ^branch_target[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (branch_taken) begin
          state_d = FETCH;
        end else if (fire && !drop_q && !slot_free) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken || !stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs of the FSM: request is live for the whole FETCH state
  always_comb begin
    imem_req  = (state_q == FETCH);
    imem_addr = pc_q;
  end

  // Datapath next state
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    pco_d        = pco_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    drop_d       = drop_q;
    if (branch_taken) begin
      pc_d         = tgt;
      valid_d      = 1'b0;
      instr_d      = 32'h0;
      skid_valid_d = 1'b0;
      skid_instr_d = 32'h0;
      skid_pc_d    = 32'h0;
      // An unanswered request must have its late ack discarded;
      // an ack landing now ends that request, so nothing stays pending.
      if (state_q == FETCH) begin
        drop_d = !imem_ack;
      end
    end else if (fire && drop_q) begin
      drop_d = 1'b0;
    end else if (fire && slot_free) begin
      instr_d = imem_rdata;
      pco_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + PC_STEP;
    end else if (fire) begin
      skid_instr_d = imem_rdata;
      skid_pc_d    = pc_q;
      skid_valid_d = 1'b1;
      pc_d         = pc_q + PC_STEP;
    end else if (state_q == HOLD && !stall) begin
      instr_d      = skid_instr_q;
      pco_d        = skid_pc_q;
      valid_d      = 1'b1;
      skid_valid_d = 1'b0;
    end else if (valid_q && !stall) begin
      valid_d = 1'b0;
      instr_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      pco_q        <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pco_q        <= pco_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign instruction_memory = instr_q;
  assign instr_valid        = valid_q;
  assign pc_out             = pco_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] bub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_q <= 32'h0;
    end else if (!valid_q && bub_q != 32'hFFFF_FFFF) begin
      bub_q <= bub_q + 32'd1;
    end
  end

  assign bubble_count = bub_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, skid/stall,
// redirect with and without drop, PC wrap, asynchronous reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instruction_memory;
  logic        instr_valid;
  logic [31:0] pc_out;
`ifdef IFETCH_PERF_EN
  logic [31:0] bubble_count;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ack           (imem_ack),
    .imem_rdata         (imem_rdata),
    .stall              (stall),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .instruction_memory (instruction_memory),
    .instr_valid        (instr_valid),
    .pc_out             (pc_out)
`ifdef IFETCH_PERF_EN
    ,
    .bubble_count       (bubble_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_word(input logic [31:0] d);
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 00000000", imem_addr); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0) begin errs++; $display("FAIL rst_instr got %h want 00000000", instruction_memory); end
    vecs++; if (pc_out !== 32'h0) begin errs++; $display("FAIL rst_pcout got %h want 00000000", pc_out); end
`ifdef IFETCH_PERF_EN
    vecs++; if (bubble_count !== 32'h0) begin errs++; $display("FAIL rst_bub got %0d want 0", bubble_count); end
`endif
    rst_n = 1'b1;
    tick();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL idle_req got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL idle_addr got %h want 00000000", imem_addr); end
`ifdef IFETCH_PERF_EN
    vecs++; if (bubble_count !== 32'd1) begin errs++; $display("FAIL idle_bub got %0d want 1", bubble_count); end
`endif
  endtask

  task automatic test_sequential();
    tick();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL seq_req0 got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL seq_addr0 got %h want 00000000", imem_addr); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL seq_valid0 got %b want 0", instr_valid); end
    ack_word(32'h0422_4020);
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL seq_valid1 got %b want 1", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0422_4020) begin errs++; $display("FAIL seq_instr1 got %h want 04224020", instruction_memory); end
    vecs++; if (pc_out !== 32'h0) begin errs++; $display("FAIL seq_pc1 got %h want 00000000", pc_out); end
    vecs++; if (imem_addr !== 32'h4) begin errs++; $display("FAIL seq_addr1 got %h want 00000004", imem_addr); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL seq_req1 got %b want 1", imem_req); end
    tick();
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL seq_bubble_v got %b want 0", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0) begin errs++; $display("FAIL seq_bubble_i got %h want 00000000", instruction_memory); end
    vecs++; if (imem_addr !== 32'h4) begin errs++; $display("FAIL seq_addr_hold got %h want 00000004", imem_addr); end
    ack_word(32'h0464_4820);
    vecs++; if (instruction_memory !== 32'h0464_4820) begin errs++; $display("FAIL seq_instr2 got %h want 04644820", instruction_memory); end
    vecs++; if (pc_out !== 32'h4) begin errs++; $display("FAIL seq_pc2 got %h want 00000004", pc_out); end
    vecs++; if (imem_addr !== 32'h8) begin errs++; $display("FAIL seq_addr2 got %h want 00000008", imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    tick();
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL stl_valid got %b want 1", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0464_4820) begin errs++; $display("FAIL stl_instr got %h want 04644820", instruction_memory); end
    ack_word(32'h0528_5022);
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL hold_req got %b want 0", imem_req); end
    vecs++; if (instruction_memory !== 32'h0464_4820) begin errs++; $display("FAIL hold_instr got %h want 04644820", instruction_memory); end
    vecs++; if (pc_out !== 32'h4) begin errs++; $display("FAIL hold_pc got %h want 00000004", pc_out); end
    tick();
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL hold_req2 got %b want 0", imem_req); end
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL hold_valid2 got %b want 1", instr_valid); end
    stall = 1'b0;
    tick();
    vecs++; if (instruction_memory !== 32'h0528_5022) begin errs++; $display("FAIL skid_instr got %h want 05285022", instruction_memory); end
    vecs++; if (pc_out !== 32'h8) begin errs++; $display("FAIL skid_pc got %h want 00000008", pc_out); end
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL skid_valid got %b want 1", instr_valid); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL skid_req got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 32'hC) begin errs++; $display("FAIL skid_addr got %h want 0000000c", imem_addr); end
    tick();
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL skid_drain got %b want 0", instr_valid); end
  endtask

  task automatic test_redirect_drop();
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken  = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rd_valid got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL rd_addr got %h want 00000100", imem_addr); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rd_req got %b want 1", imem_req); end
    tick();
    ack_word(32'hDEAD_BEEF);
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rd_dropv got %b want 0", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0) begin errs++; $display("FAIL rd_dropi got %h want 00000000", instruction_memory); end
    vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL rd_reissue got %h want 00000100", imem_addr); end
    ack_word(32'h0010_0093);
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL rd_tgt_v got %b want 1", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0010_0093) begin errs++; $display("FAIL rd_tgt_i got %h want 00100093", instruction_memory); end
    vecs++; if (pc_out !== 32'h100) begin errs++; $display("FAIL rd_tgt_pc got %h want 00000100", pc_out); end
    vecs++; if (imem_addr !== 32'h104) begin errs++; $display("FAIL rd_next got %h want 00000104", imem_addr); end
  endtask

  task automatic test_redirect_ack();
    branch_taken  = 1'b1;
    branch_target = 32'h203;
    ack_word(32'h1111_1111);
    branch_taken  = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL ra_valid got %b want 0", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0) begin errs++; $display("FAIL ra_instr got %h want 00000000", instruction_memory); end
    vecs++; if (imem_addr !== 32'h200) begin errs++; $display("FAIL ra_addr got %h want 00000200", imem_addr); end
    ack_word(32'h2222_2222);
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL ra_nodrop_v got %b want 1", instr_valid); end
    vecs++; if (instruction_memory !== 32'h2222_2222) begin errs++; $display("FAIL ra_nodrop_i got %h want 22222222", instruction_memory); end
    vecs++; if (pc_out !== 32'h200) begin errs++; $display("FAIL ra_pc got %h want 00000200", pc_out); end
  endtask

  task automatic test_pc_wrap();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    tick();
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL wr_stallflush_v got %b want 0", instr_valid); end
    vecs++; if (instruction_memory !== 32'h0) begin errs++; $display("FAIL wr_stallflush_i got %h want 00000000", instruction_memory); end
    vecs++; if (imem_addr !== 32'h300) begin errs++; $display("FAIL wr_addr1 got %h want 00000300", imem_addr); end
    stall         = 1'b0;
    branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken  = 1'b0;
    vecs++; if (imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wr_addr2 got %h want fffffffc", imem_addr); end
    ack_word(32'h0BAD_BAD0);
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL wr_drop got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wr_reissue got %h want fffffffc", imem_addr); end
    ack_word(32'h3333_3333);
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL wr_valid got %b want 1", instr_valid); end
    vecs++; if (pc_out !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wr_pc got %h want fffffffc", pc_out); end
    vecs++; if (instruction_memory !== 32'h3333_3333) begin errs++; $display("FAIL wr_instr got %h want 33333333", instruction_memory); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL wr_wrap got %h want 00000000", imem_addr); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mrst_req got %b want 0", imem_req); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL mrst_valid got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL mrst_addr got %h want 00000000", imem_addr); end
    vecs++; if (instruction_memory !== 32'h0) begin errs++; $display("FAIL mrst_instr got %h want 00000000", instruction_memory); end
    vecs++; if (pc_out !== 32'h0) begin errs++; $display("FAIL mrst_pc got %h want 00000000", pc_out); end
`ifdef IFETCH_PERF_EN
    vecs++; if (bubble_count !== 32'h0) begin errs++; $display("FAIL mrst_bub got %0d want 0", bubble_count); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL mrst_rel_req got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL mrst_rel_addr got %h want 00000000", imem_addr); end
    tick();
`ifdef IFETCH_PERF_EN
    vecs++; if (bubble_count !== 32'd2) begin errs++; $display("FAIL mrst_bub2 got %0d want 2", bubble_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_redirect_ack();
    test_pc_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
